// File: rtl/ps2_device_tx.sv
// ps2_device_tx: the keyboard (device) end of a PS/2 link.
// Scancode bytes come in on a valid/ready handshake and wait in a small FIFO.
// Each byte then goes out as an 11-bit device-to-host frame: a start bit,
// eight data bits LSB first, odd parity and a stop bit. The frame is clocked
// by a ps2_clk that this block generates itself.
//
// Ports:
//   clk, resetn        system clock; synchronous active-low reset
//   data_in, valid     byte to send; taken when valid && ready at a clk edge
//   ready              FIFO has room
//   ps2_clk, ps2_data  PS/2 lines to the host; both idle high; registered
//   busy               a frame or the inter-frame gap is in progress
//   frame_done         one-cycle pulse after the stop bit's low phase ends
//   fifo_count         number of bytes buffered
module ps2_device_tx #(
    parameter int CLK_DIV    = 4,   // clk cycles per ps2_clk half-period, >= 2
    parameter int GAP_CYCLES = 8,   // idle cycles between frames
    parameter int FIFO_DEPTH = 8    // power of 2, >= 2
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic [7:0]                  data_in,
    input  logic                        valid,
    output logic                        ready,
    output logic                        ps2_clk,
    output logic                        ps2_data,
    output logic                        busy,
    output logic                        frame_done,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DW = $clog2(CLK_DIV);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, HIGH, LOW, GAP} state_e;

    state_e         state_q, state_d;
    logic [DW-1:0]  div_q, div_d;      // position within a ps2_clk half-period
    logic [GW-1:0]  gap_q, gap_d;      // position within the inter-frame gap
    logic [3:0]     bit_q, bit_d;      // frame bit currently on ps2_data
    logic [9:0]     sh_q, sh_d;        // frame bits still to send, next one in [0]
    logic           clk_q, clk_d;
    logic           dat_q, dat_d;
    logic           done_q, done_d;
    logic [AW:0]    wr_q, wr_d;
    logic [AW:0]    rd_q, rd_d;
    logic [AW:0]    cnt_q, cnt_d;
    logic [7:0]     mem [FIFO_DEPTH];

    logic       push, pop;
    logic [7:0] head;

    assign ready      = (cnt_q != (AW+1)'(FIFO_DEPTH));
    assign push       = valid && ready;
    assign pop        = (state_q == IDLE) && (cnt_q != '0);
    assign head       = mem[rd_q[AW-1:0]];
    assign busy       = (state_q != IDLE);
    assign ps2_clk    = clk_q;
    assign ps2_data   = dat_q;
    assign frame_done = done_q;
    assign fifo_count = cnt_q;

    // Storage needs no reset: the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_q[AW-1:0]] <= data_in;
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        gap_d   = gap_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        clk_d   = clk_q;
        dat_d   = dat_q;
        done_d  = 1'b0;
        wr_d    = push ? wr_q + 1'b1 : wr_q;
        rd_d    = pop  ? rd_q + 1'b1 : rd_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase

        case (state_q)
            IDLE: begin
                clk_d = 1'b1;
                dat_d = 1'b1;
                if (pop) begin
                    // Start bit goes out now; the rest are queued behind it.
                    sh_d    = {1'b1, ~^head, head};
                    dat_d   = 1'b0;
                    bit_d   = '0;
                    div_d   = '0;
                    state_d = HIGH;
                end
            end
            HIGH: begin
                if (div_q == DW'(CLK_DIV-1)) begin
                    div_d   = '0;
                    clk_d   = 1'b0;
                    state_d = LOW;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            LOW: begin
                if (div_q == DW'(CLK_DIV-1)) begin
                    div_d = '0;
                    clk_d = 1'b1;
                    if (bit_q == 4'd10) begin
                        dat_d   = 1'b1;
                        done_d  = 1'b1;
                        gap_d   = '0;
                        state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
                    end else begin
                        // Data only moves on the rising ps2_clk edge, so it is
                        // settled for a full half-period before the host samples.
                        bit_d   = bit_q + 1'b1;
                        dat_d   = sh_q[0];
                        sh_d    = {1'b0, sh_q[9:1]};
                        state_d = HIGH;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            GAP: begin
                if (gap_q == GW'(GAP_CYCLES-1)) begin
                    gap_d   = '0;
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            div_q   <= '0;
            gap_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            clk_q   <= 1'b1;
            dat_q   <= 1'b1;
            done_q  <= 1'b0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            gap_q   <= gap_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            clk_q   <= clk_d;
            dat_q   <= dat_d;
            done_q  <= done_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_ps2_device_tx.sv
// Bench for ps2_device_tx. Accepted bytes go into an expected queue; a
// host-side monitor samples ps2_data at every ps2_clk falling edge, rebuilds
// each 11-bit frame and compares it with the frame the oldest expected byte
// should produce. Directed sections check latencies and FIFO boundaries.
module tb_ps2_device_tx;
    localparam int CLK_DIV    = 4;
    localparam int GAP_CYCLES = 8;
    localparam int FIFO_DEPTH = 8;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       valid = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       ready, ps2_clk, ps2_data, busy, frame_done;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    ps2_device_tx #(.CLK_DIV(CLK_DIV), .GAP_CYCLES(GAP_CYCLES), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .resetn(resetn), .data_in(data_in), .valid(valid), .ready(ready),
        .ps2_clk(ps2_clk), .ps2_data(ps2_data), .busy(busy), .frame_done(frame_done),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Frame a host should see for byte b: start 0, data LSB first, odd parity, stop 1.
    function automatic logic [10:0] exp_frame(input logic [7:0] b);
        logic [10:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = (b >> i) & 8'd1;
        f[9]  = ($countones(b) % 2 == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    // Host-side monitor.
    int          bitcnt = 0;
    logic [10:0] bits = '0;
    bit          pend_done = 0;
    int          fall_cyc = 0;
    int          start_cyc = -100;
    logic        prev_clk = 1'b1, prev_data = 1'b1, prev_busy = 1'b0;

    always @(negedge clk) begin
        logic [7:0] b;
        if (!resetn) begin
            bitcnt    = 0;
            pend_done = 0;
            exp_q.delete();
        end else begin
            if (!prev_clk && !ps2_clk) chk("data_stable_low", ps2_data, prev_data);
            if (prev_clk && !ps2_clk) begin
                bits[bitcnt] = ps2_data;
                bitcnt++;
                if (bitcnt == 11) begin
                    bitcnt    = 0;
                    pend_done = 1;
                    fall_cyc  = cyc;
                    if (exp_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL frame_unexpected: got %b want none", bits);
                    end else begin
                        b = exp_q.pop_front();
                        chk("frame", bits, exp_frame(b));
                    end
                end
            end
            if (frame_done) begin
                chk("done_pending", pend_done, 1);
                chk("done_delay", cyc - fall_cyc, CLK_DIV);
                pend_done = 0;
            end
            if (!prev_busy && busy) start_cyc = cyc;
        end
        prev_clk  = ps2_clk;
        prev_data = ps2_data;
        prev_busy = busy;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic cur(input int sel);
        case (sel)
            0:       return busy;
            1:       return ps2_clk;
            2:       return frame_done;
            3:       return (bitcnt == 6);
            default: return (exp_q.size() == 0) && !busy && (fifo_count == 0);
        endcase
    endfunction

    task automatic wait_sig(input int sel, input logic val, input int lim, input string nm);
        int n = 0;
        while (cur(sel) !== val && n < lim) begin
            step();
            n++;
        end
        if (cur(sel) !== val) begin
            total++; bad++;
            $display("FAIL timeout_%s: got %b want %b", nm, cur(sel), val);
        end
    endtask

    // Called just after a clock edge; leaves valid high for the caller to drop.
    task automatic push_byte(input logic [7:0] b, output int acc);
        logic rdy;
        int   n = 0;
        data_in = b;
        valid   = 1'b1;
        acc     = -1;
        forever begin
            rdy = ready;
            step();
            if (rdy) begin
                exp_q.push_back(b);
                acc = cyc;
                break;
            end
            n++;
            if (n > 400) begin
                total++; bad++;
                $display("FAIL push_timeout: got ready=0 want ready=1");
                break;
            end
        end
    endtask

    initial begin
        int         ac, t0, n;
        logic [7:0] b;

        // Reset state
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ps2_clk", ps2_clk, 1);
        chk("rst_ps2_data", ps2_data, 1);
        chk("rst_ready", ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_done", frame_done, 0);
        resetn = 1'b1;
        step();

        // Single byte 0x1C: first-transaction latencies
        push_byte(8'h1C, ac);
        valid = 1'b0;
        chk("t2_count_after_push", fifo_count, 1);
        chk("t2_busy_before_pop", busy, 0);
        chk("t2_data_before_pop", ps2_data, 1);
        step();
        t0 = cyc;
        chk("t2_busy_after_pop", busy, 1);
        chk("t2_start_bit", ps2_data, 0);
        chk("t2_count_after_pop", fifo_count, 0);
        chk("t2_clk_high", ps2_clk, 1);
        wait_sig(1, 1'b0, 50, "first_fall");
        chk("t2_first_fall", cyc - t0, CLK_DIV);
        wait_sig(2, 1'b1, 300, "done");
        chk("t2_done_latency", cyc - t0, 22*CLK_DIV);
        t0 = cyc;
        wait_sig(0, 1'b0, 100, "gap_end");
        chk("t2_gap_len", cyc - t0, GAP_CYCLES);

        // Back-to-back F0, 1C
        push_byte(8'hF0, ac);
        push_byte(8'h1C, ac);
        valid = 1'b0;
        wait_sig(2, 1'b1, 300, "b2b_done");
        t0 = cyc;
        wait_sig(0, 1'b0, 100, "b2b_idle");
        wait_sig(0, 1'b1, 100, "b2b_start");
        chk("t3_second_start", cyc - t0, GAP_CYCLES + 1);
        chk("t3_second_start_bit", ps2_data, 0);
        wait_sig(4, 1'b1, 500, "b2b_drain");

        // Fill the FIFO while a frame is in flight
        push_byte($urandom_range(0, 255), ac);
        valid = 1'b0;
        wait_sig(0, 1'b1, 50, "fill_start");
        for (int i = 0; i < 9; i++) begin
            push_byte($urandom_range(0, 255), ac);
            if (i == 7) begin
                chk("t4_full_count", fifo_count, FIFO_DEPTH);
                chk("t4_full_ready", ready, 0);
            end
            if (i == 8) chk("t4_accept_after_pop", ac - start_cyc, 1);
        end
        valid = 1'b0;
        wait_sig(4, 1'b1, 3000, "fill_drain");

        // Reset during the low phase of data bit 4
        push_byte($urandom_range(0, 255), ac);
        push_byte($urandom_range(0, 255), ac);
        valid = 1'b0;
        wait_sig(3, 1'b1, 300, "bit4_low");
        chk("t5_in_low", ps2_clk, 0);
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        chk("t5_ps2_clk", ps2_clk, 1);
        chk("t5_ps2_data", ps2_data, 1);
        chk("t5_busy", busy, 0);
        chk("t5_count", fifo_count, 0);
        chk("t5_ready", ready, 1);
        n = 0;
        repeat (150) begin
            step();
            if (frame_done || busy) n++;
        end
        chk("t5_quiet_after_rst", n, 0);
        push_byte($urandom_range(0, 255), ac);
        valid = 1'b0;
        wait_sig(4, 1'b1, 500, "rst_drain");

        // Simultaneous push and pop with 3 buffered
        for (int i = 0; i < 4; i++) push_byte($urandom_range(0, 255), ac);
        valid = 1'b0;
        chk("t6_count3_busy", fifo_count, 3);
        wait_sig(0, 1'b0, 300, "t6_idle");
        chk("t6_count3_idle", fifo_count, 3);
        push_byte($urandom_range(0, 255), ac);
        valid = 1'b0;
        chk("t6_count_pushpop", fifo_count, 3);
        chk("t6_busy_pushpop", busy, 1);
        wait_sig(4, 1'b1, 1000, "t6_drain");

        // Random traffic
        for (int i = 0; i < 24; i++) begin
            push_byte($urandom_range(0, 255), ac);
            if ($urandom_range(0, 2) != 0) begin
                valid = 1'b0;
                repeat ($urandom_range(0, 120)) step();
            end
        end
        valid = 1'b0;
        wait_sig(4, 1'b1, 5000, "rand_drain");
        chk("final_queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end
endmodule
